obb_integrator: RTL

Physics-step engine for one oriented bounding box. On a one-cycle `step` pulse it samples the current OBB state from the box's register outputs and integrates one frame:
- gravity into y velocity;
- velocity into position;
- angular rate into angle;
- clamp and bounce against playfield walls.

It then drives the box register's parallel-load bus for exactly one cycle. It is the writer/driver on that register's `ld_*` / `load` interface.

---
 rtl/obb_integrator_if.sv | 43 ++++
 rtl/obb_integrator.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/obb_integrator_if.sv
// Bundle between one OBB state register and its physics integrator:
// current-state fields and step in, parallel-load bus and status out.
interface obb_integrator_if #(
    parameter int POS_W   = 16,
    parameter int VEL_W   = 12,
    parameter int ANGLE_W = 12,
    parameter int OMEGA_W = 8,
    parameter int SIZE_W  = 8
);
    logic               step;
    logic [POS_W-1:0]   pos_x;
    logic [POS_W-1:0]   pos_y;
    logic [VEL_W-1:0]   vel_x;
    logic [VEL_W-1:0]   vel_y;
    logic [SIZE_W-1:0]  width;
    logic [SIZE_W-1:0]  height;
    logic [ANGLE_W-1:0] angle;
    logic [OMEGA_W-1:0] omega;

    logic [POS_W-1:0]   ld_pos_x;
    logic [POS_W-1:0]   ld_pos_y;
    logic [VEL_W-1:0]   ld_vel_x;
    logic [VEL_W-1:0]   ld_vel_y;
    logic [SIZE_W-1:0]  ld_width;
    logic [SIZE_W-1:0]  ld_height;
    logic [ANGLE_W-1:0] ld_angle;
    logic [OMEGA_W-1:0] ld_omega;
    logic               load;
    logic               busy;
    logic               done;

    modport master (
        output step, pos_x, pos_y, vel_x, vel_y, width, height, angle, omega,
        input  ld_pos_x, ld_pos_y, ld_vel_x, ld_vel_y, ld_width, ld_height,
               ld_angle, ld_omega, load, busy, done
    );

    modport slave (
        input  step, pos_x, pos_y, vel_x, vel_y, width, height, angle, omega,
        output ld_pos_x, ld_pos_y, ld_vel_x, ld_vel_y, ld_width, ld_height,
               ld_angle, ld_omega, load, busy, done
    );
endinterface

// File: rtl/obb_integrator.sv
// One-frame physics step for a single oriented bounding box: gravity,
// position/angle integration, wall clamp with bounce, then a one-cycle load.
//
// state | meaning
// IDLE  | waiting for step; inputs captured on the accepting edge
// INTEG | gravity into vy, velocity into position, omega into angle
// BOUND | per-axis wall clamp and bounce; ld_* registers written
// WRITE | load/done strobe, ld_* hold the new frame
module obb_integrator #(
    parameter int POS_W    = 16,
    parameter int POS_FRAC = 4,
    parameter int VEL_W    = 12,
    parameter int ANGLE_W  = 12,
    parameter int OMEGA_W  = 8,
    parameter int SIZE_W   = 8,
    parameter int GRAVITY  = 2,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 639,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 479
) (
    input logic            clk,
    input logic            reset,
    obb_integrator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, INTEG, BOUND, WRITE} state_t;

    localparam logic signed [POS_W:0]   X_LO  = (POS_W+1)'(X_MIN * (2 ** POS_FRAC));
    localparam logic signed [POS_W:0]   X_HI  = (POS_W+1)'(X_MAX * (2 ** POS_FRAC));
    localparam logic signed [POS_W:0]   Y_LO  = (POS_W+1)'(Y_MIN * (2 ** POS_FRAC));
    localparam logic signed [POS_W:0]   Y_HI  = (POS_W+1)'(Y_MAX * (2 ** POS_FRAC));
    localparam logic signed [VEL_W-1:0] V_MAX = {1'b0, {(VEL_W-1){1'b1}}};
    localparam logic signed [VEL_W-1:0] V_MIN = {1'b1, {(VEL_W-1){1'b0}}};
    localparam logic signed [VEL_W:0]   GRAV  = (VEL_W+1)'(GRAVITY);

    state_t r_state;
    state_t w_next;
    logic   w_load;
    logic   w_busy;

    logic signed [POS_W:0]   r_px;
    logic signed [POS_W:0]   r_py;
    logic signed [VEL_W-1:0] r_vx;
    logic signed [VEL_W-1:0] r_vy;
    logic [ANGLE_W-1:0]      r_ang;
    logic [OMEGA_W-1:0]      r_om;
    logic [SIZE_W-1:0]       r_w;
    logic [SIZE_W-1:0]       r_h;

    logic [POS_W-1:0]   r_ld_px;
    logic [POS_W-1:0]   r_ld_py;
    logic [VEL_W-1:0]   r_ld_vx;
    logic [VEL_W-1:0]   r_ld_vy;
    logic [SIZE_W-1:0]  r_ld_w;
    logic [SIZE_W-1:0]  r_ld_h;
    logic [ANGLE_W-1:0] r_ld_ang;
    logic [OMEGA_W-1:0] r_ld_om;

    logic signed [VEL_W:0]   w_vy_sum;
    logic signed [VEL_W-1:0] w_vy_sat;
    logic signed [POS_W:0]   w_px_int;
    logic signed [POS_W:0]   w_py_int;
    logic [ANGLE_W-1:0]      w_ang_int;
    logic signed [VEL_W-1:0] w_vx_abs;
    logic signed [VEL_W-1:0] w_vy_abs;
    logic [POS_W-1:0]        w_px_fin;
    logic [POS_W-1:0]        w_py_fin;
    logic signed [VEL_W-1:0] w_vx_fin;
    logic signed [VEL_W-1:0] w_vy_fin;

    // The most negative velocity has no positive twin; it bounces as V_MAX.
    function automatic logic signed [VEL_W-1:0] f_abs(input logic signed [VEL_W-1:0] v);
        if (v == V_MIN)
            return V_MAX;
        else if (v < 0)
            return -v;
        else
            return v;
    endfunction

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_busy = 1'b0;
        case (r_state)
            IDLE:  if (bus.step) w_next = INTEG;
            INTEG: begin
                w_busy = 1'b1;
                w_next = BOUND;
            end
            BOUND: begin
                w_busy = 1'b1;
                w_next = WRITE;
            end
            WRITE: begin
                w_busy = 1'b1;
                w_load = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_vy_sum = {r_vy[VEL_W-1], r_vy} + GRAV;
        if (w_vy_sum[VEL_W] != w_vy_sum[VEL_W-1])
            w_vy_sat = w_vy_sum[VEL_W] ? V_MIN : V_MAX;
        else
            w_vy_sat = w_vy_sum[VEL_W-1:0];
        w_px_int  = r_px + {{(POS_W+1-VEL_W){r_vx[VEL_W-1]}}, r_vx};
        w_py_int  = r_py + {{(POS_W+1-VEL_W){w_vy_sat[VEL_W-1]}}, w_vy_sat};
        w_ang_int = r_ang + {{(ANGLE_W-OMEGA_W){r_om[OMEGA_W-1]}}, r_om};
    end

    always_comb begin
        w_vx_abs = f_abs(r_vx);
        w_vy_abs = f_abs(r_vy);
        w_px_fin = r_px[POS_W-1:0];
        w_vx_fin = r_vx;
        w_py_fin = r_py[POS_W-1:0];
        w_vy_fin = r_vy;
        if (r_px < X_LO) begin
            w_px_fin = X_LO[POS_W-1:0];
            w_vx_fin = w_vx_abs;
        end else if (r_px > X_HI) begin
            w_px_fin = X_HI[POS_W-1:0];
            w_vx_fin = -w_vx_abs;
        end
        if (r_py < Y_LO) begin
            w_py_fin = Y_LO[POS_W-1:0];
            w_vy_fin = w_vy_abs;
        end else if (r_py > Y_HI) begin
            w_py_fin = Y_HI[POS_W-1:0];
            w_vy_fin = -w_vy_abs;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_px     <= '0;
            r_py     <= '0;
            r_vx     <= '0;
            r_vy     <= '0;
            r_ang    <= '0;
            r_om     <= '0;
            r_w      <= '0;
            r_h      <= '0;
            r_ld_px  <= '0;
            r_ld_py  <= '0;
            r_ld_vx  <= '0;
            r_ld_vy  <= '0;
            r_ld_w   <= '0;
            r_ld_h   <= '0;
            r_ld_ang <= '0;
            r_ld_om  <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.step) begin
                    r_px  <= {bus.pos_x[POS_W-1], bus.pos_x};
                    r_py  <= {bus.pos_y[POS_W-1], bus.pos_y};
                    r_vx  <= bus.vel_x;
                    r_vy  <= bus.vel_y;
                    r_ang <= bus.angle;
                    r_om  <= bus.omega;
                    r_w   <= bus.width;
                    r_h   <= bus.height;
                end
                INTEG: begin
                    r_px  <= w_px_int;
                    r_py  <= w_py_int;
                    r_vy  <= w_vy_sat;
                    r_ang <= w_ang_int;
                end
                BOUND: begin
                    r_ld_px  <= w_px_fin;
                    r_ld_py  <= w_py_fin;
                    r_ld_vx  <= w_vx_fin;
                    r_ld_vy  <= w_vy_fin;
                    r_ld_w   <= r_w;
                    r_ld_h   <= r_h;
                    r_ld_ang <= r_ang;
                    r_ld_om  <= r_om;
                end
                default: ;
            endcase
        end
    end

    assign bus.ld_pos_x  = r_ld_px;
    assign bus.ld_pos_y  = r_ld_py;
    assign bus.ld_vel_x  = r_ld_vx;
    assign bus.ld_vel_y  = r_ld_vy;
    assign bus.ld_width  = r_ld_w;
    assign bus.ld_height = r_ld_h;
    assign bus.ld_angle  = r_ld_ang;
    assign bus.ld_omega  = r_ld_om;
    assign bus.load      = w_load;
    assign bus.done      = w_load;
    assign bus.busy      = w_busy;
endmodule
